// File: rtl/axi_vfifo_ram_resp.sv
// AXI4 slave RAM used as the vfifo backing store: independent write (AW/W/B) and read (AR/R) bursts.
// Optional macro AXI_VFIFO_RAM_OUT_REG_EN adds a 2-entry registered skid stage on the R channel.
`timescale 1ns/1ps
module axi_vfifo_ram_resp #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_req_int,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
  localparam int IDX_W     = ADDR_WIDTH - SIZE_LOG2;
  localparam int DEPTH     = 2**IDX_W;
  localparam logic [2:0] FULL_SIZE = 3'(SIZE_LOG2);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic r_rdy_en;
  wstate_t r_wstate, w_wnext;
  rstate_t r_rstate, w_rnext;

  logic [ID_WIDTH-1:0] r_wid, r_rid;
  logic [IDX_W-1:0]    r_widx, r_ridx, w_ar_idx;
  logic [7:0]          r_wlen, r_wcnt, r_rlen, r_rcnt;
  logic                r_winc, r_werr, r_rinc, r_rerr, w_ar_inc;
  logic                r_cvalid, r_clast;
  logic [DATA_WIDTH-1:0] r_cdata;
  logic w_aw_hs, w_w_hs, w_w_final, w_ar_hs, w_c_hs, w_cready;
  logic w_unused_addr_bits;

  // FIXED is the only burst that holds the index; WRAP and reserved fall back to INCR but are flagged.
  function automatic logic f_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size != FULL_SIZE) || burst[1];
  endfunction

  assign w_unused_addr_bits = ^{s_axi_awaddr[SIZE_LOG2-1:0], s_axi_araddr[SIZE_LOG2-1:0]};

  assign w_aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_w_hs    = s_axi_wvalid && s_axi_wready;
  assign w_w_final = (r_wcnt == r_wlen);
  assign w_ar_hs   = s_axi_arvalid && s_axi_arready;
  assign w_ar_idx  = s_axi_araddr[ADDR_WIDTH-1:SIZE_LOG2];
  assign w_ar_inc  = (s_axi_arburst != 2'b00);
  assign w_c_hs    = r_cvalid && w_cready;

  // Keeps address readies low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst_req_int) begin
    if (rst_req_int) r_rdy_en <= 1'b0;
    else             r_rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst_req_int) begin
    if (rst_req_int) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
      W_DATA:  if (w_w_hs && w_w_final) w_wnext = W_RESP;
      W_RESP:  if (s_axi_bready) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (w_c_hs && r_clast) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  assign s_axi_awready = (r_wstate == W_IDLE) && r_rdy_en;
  assign s_axi_wready  = (r_wstate == W_DATA);
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bid     = r_wid;
  assign s_axi_bresp   = {r_werr, 1'b0};
  assign s_axi_arready = (r_rstate == R_IDLE) && r_rdy_en;

  // The beat counter alone ends the burst; a misplaced wlast only poisons the response.
  always_ff @(posedge clk or posedge rst_req_int) begin
    if (rst_req_int) begin
      r_wid  <= '0;
      r_widx <= '0;
      r_wlen <= '0;
      r_wcnt <= '0;
      r_winc <= 1'b0;
      r_werr <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid  <= s_axi_awid;
      r_widx <= s_axi_awaddr[ADDR_WIDTH-1:SIZE_LOG2];
      r_wlen <= s_axi_awlen;
      r_wcnt <= '0;
      r_winc <= (s_axi_awburst != 2'b00);
      r_werr <= f_bad(s_axi_awsize, s_axi_awburst);
    end else if (w_w_hs) begin
      r_wcnt <= r_wcnt + 8'd1;
      r_widx <= r_widx + {{(IDX_W-1){1'b0}}, r_winc};
      if (s_axi_wlast != w_w_final) r_werr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read core fetches each beat one edge ahead; a same-edge write is not yet visible (read-before-write).
  always_ff @(posedge clk or posedge rst_req_int) begin
    if (rst_req_int) begin
      r_rid    <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rinc   <= 1'b0;
      r_rerr   <= 1'b0;
      r_cvalid <= 1'b0;
      r_clast  <= 1'b0;
      r_cdata  <= '0;
    end else if (w_ar_hs) begin
      r_rid    <= s_axi_arid;
      r_rlen   <= s_axi_arlen;
      r_rcnt   <= '0;
      r_rinc   <= w_ar_inc;
      r_rerr   <= f_bad(s_axi_arsize, s_axi_arburst);
      r_ridx   <= w_ar_idx + {{(IDX_W-1){1'b0}}, w_ar_inc};
      r_cdata  <= r_mem[w_ar_idx];
      r_cvalid <= 1'b1;
      r_clast  <= (s_axi_arlen == 8'd0);
    end else if (w_c_hs) begin
      if (r_clast) begin
        r_cvalid <= 1'b0;
        r_clast  <= 1'b0;
      end else begin
        r_cdata <= r_mem[r_ridx];
        r_ridx  <= r_ridx + {{(IDX_W-1){1'b0}}, r_rinc};
        r_rcnt  <= r_rcnt + 8'd1;
        r_clast <= ((r_rcnt + 8'd1) == r_rlen);
      end
    end
  end

`ifdef AXI_VFIFO_RAM_OUT_REG_EN
  localparam int BEAT_W = ID_WIDTH + 2 + 1 + DATA_WIDTH;

  logic [BEAT_W-1:0] r_q [2];
  logic              r_qwr, r_qrd;
  logic [1:0]        r_qcnt;
  logic              w_pop;
  logic [BEAT_W-1:0] w_core_beat;

  // Ready to the core comes from the registered fill level, so no combinational path from rready.
  assign w_cready    = (r_qcnt != 2'd2);
  assign w_pop       = (r_qcnt != 2'd0) && s_axi_rready;
  assign w_core_beat = {r_rid, r_rerr, 1'b0, r_clast, r_cdata};
  assign s_axi_rvalid = (r_qcnt != 2'd0);
  assign {s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata} = r_q[r_qrd];

  always_ff @(posedge clk or posedge rst_req_int) begin
    if (rst_req_int) begin
      r_q[0] <= '0;
      r_q[1] <= '0;
      r_qwr  <= 1'b0;
      r_qrd  <= 1'b0;
      r_qcnt <= '0;
    end else begin
      if (w_c_hs) begin
        r_q[r_qwr] <= w_core_beat;
        r_qwr      <= ~r_qwr;
      end
      if (w_pop) r_qrd <= ~r_qrd;
      r_qcnt <= r_qcnt + {1'b0, w_c_hs} - {1'b0, w_pop};
    end
  end
`else
  assign w_cready     = s_axi_rready;
  assign s_axi_rvalid = r_cvalid;
  assign s_axi_rdata  = r_cdata;
  assign s_axi_rlast  = r_clast;
  assign s_axi_rid    = r_rid;
  assign s_axi_rresp  = {r_rerr, 1'b0};
`endif

endmodule

// File: tb/tb_axi_vfifo_ram_resp.sv
// Randomized self-checking bench for axi_vfifo_ram_resp against a byte-level memory model.
// Honours AXI_VFIFO_RAM_OUT_REG_EN for the expected read latency.
`timescale 1ns/1ps
module tb_axi_vfifo_ram_resp;
  localparam int DEPTH = 8192;
`ifdef AXI_VFIFO_RAM_OUT_REG_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk, rst_req_int;
  logic [7:0]  awid, awlen, bid, arid, arlen, rid;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] m_mem [DEPTH];
  logic [63:0] m_known [DEPTH];
  logic [63:0] wbuf_data [256];
  logic [7:0]  wbuf_strb [256];

  logic [63:0] rc_data [$];
  logic        rc_last [$];
  logic [1:0]  rc_resp [$];
  logic [7:0]  rc_id [$];
  int rc_lat, rc_unstable;

  axi_vfifo_ram_resp dut (
    .clk(clk), .rst_req_int(rst_req_int),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  // Model: word index = byte address / 8, modulo depth; FIXED holds the index, every other burst steps.
  function automatic void model_write(input int addr, input int len, input logic [1:0] burst);
    int idx;
    idx = (addr / 8) % DEPTH;
    for (int i = 0; i <= len; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (wbuf_strb[i][b]) begin
          m_mem[idx][b*8 +: 8]   = wbuf_data[i][b*8 +: 8];
          m_known[idx][b*8 +: 8] = 8'hFF;
        end
      end
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
  endfunction

  function automatic int model_idx(input int addr, input int beat, input logic [1:0] burst);
    return (addr / 8 + ((burst == 2'b00) ? 0 : beat)) % DEPTH;
  endfunction

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [7:0] id, input int flip_beat,
                          output logic [1:0] resp, output logic [7:0] rbid, output bit timeout);
    int n;
    timeout = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) timeout = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf_data[i]; wstrb = wbuf_strb[i];
      wlast = (i == int'(len)) != (i == flip_beat);
      wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) timeout = 1'b1;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) timeout = 1'b1;
    resp = bresp; rbid = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // mode 0: rready held high, 1: toggles 1/0 every cycle, 2: random
  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [7:0] id, input int mode,
                         output bit timeout);
    int n, cycles;
    bit got_last, prev_stall;
    logic [63:0] pd; logic pl; logic [7:0] pi; logic [1:0] pr;
    rc_data.delete(); rc_last.delete(); rc_resp.delete(); rc_id.delete();
    rc_lat = 0; rc_unstable = 0; timeout = 1'b0;
    pd = '0; pl = 1'b0; pi = '0; pr = '0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) timeout = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    cycles = 0; got_last = 1'b0; prev_stall = 1'b0;
    while (!got_last && cycles < 2000) begin
      if (mode == 0) rready = 1'b1;
      else if (mode == 1) rready = (cycles % 2 == 0);
      else rready = 1'($urandom_range(0, 1));
      if (rvalid === 1'b1 && rc_lat == 0) rc_lat = cycles + 1;
      if (prev_stall && (rvalid !== 1'b1 || rdata !== pd || rlast !== pl || rid !== pi || rresp !== pr))
        rc_unstable++;
      if (rvalid === 1'b1 && rready) begin
        rc_data.push_back(rdata); rc_last.push_back(rlast);
        rc_resp.push_back(rresp); rc_id.push_back(rid);
        if (rlast === 1'b1) got_last = 1'b1;
      end
      prev_stall = (rvalid === 1'b1) && !rready;
      pd = rdata; pl = rlast; pi = rid; pr = rresp;
      @(posedge clk); #1;
      cycles++;
    end
    rready = 1'b0;
    if (!got_last) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_req_int = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (awready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_awready: got %b expected 0", awready); end
    n_checks++; if (arready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_arready: got %b expected 0", arready); end
    n_checks++; if (wready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wready: got %b expected 0", wready); end
    n_checks++; if (bvalid !== 1'b0 || bresp !== 2'b00 || bid !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_b: got v=%b r=%b id=%h expected 0", bvalid, bresp, bid); end
    n_checks++; if (rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 || rid !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_r: got v=%b l=%b r=%b id=%h expected 0", rvalid, rlast, rresp, rid); end
    n_checks++; if (rdata !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    @(negedge clk);
    rst_req_int = 1'b0;
    #1;
    n_checks++; if (awready !== 1'b0) begin n_fail++; $display("[TB] FAIL release_pre_edge: got %b expected 0", awready); end
    @(posedge clk); #1;
    n_checks++; if (awready !== 1'b1 || arready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_ready: got aw=%b ar=%b expected 1 1", awready, arready); end
  endtask

  task automatic test_incr_basic();
    logic [1:0] r; logic [7:0] id; bit to, rto;
    for (int i = 0; i < 4; i++) begin wbuf_data[i] = 64'(8'h11 * (i + 1)); wbuf_strb[i] = 8'hFF; end
    do_write(16'h0040, 8'd3, 2'b01, 3'd3, 8'h5A, -1, r, id, to);
    model_write(16'h0040, 3, 2'b01);
    n_checks++; if (to !== 1'b0 || r !== 2'b00 || id !== 8'h5A) begin n_fail++; $display("[TB] FAIL incr_bresp: got to=%b resp=%b id=%h expected 0 00 5a", to, r, id); end
    do_read(16'h0040, 8'd3, 2'b01, 3'd3, 8'hA5, 0, rto);
    n_checks++; if (rto !== 1'b0 || rc_data.size() !== 4) begin n_fail++; $display("[TB] FAIL incr_rcount: got to=%b beats=%0d expected 0 4", rto, rc_data.size()); end
    n_checks++; if (rc_lat !== EXP_LAT) begin n_fail++; $display("[TB] FAIL incr_latency: got %0d expected %0d", rc_lat, EXP_LAT); end
    for (int i = 0; i < rc_data.size() && i < 4; i++) begin
      n_checks++;
      if (rc_data[i] !== 64'(8'h11 * (i + 1)) || rc_last[i] !== (i == 3) || rc_id[i] !== 8'hA5 || rc_resp[i] !== 2'b00) begin
        n_fail++; $display("[TB] FAIL incr_beat%0d: got d=%h l=%b id=%h r=%b expected d=%h l=%b id=a5 r=00",
                           i, rc_data[i], rc_last[i], rc_id[i], rc_resp[i], 64'(8'h11 * (i + 1)), (i == 3));
      end
    end
    n_checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_fail++; $display("[TB] FAIL incr_after: got rvalid=%b arready=%b expected 0 1", rvalid, arready); end
  endtask

  task automatic test_wrap_top();
    logic [1:0] r; logic [7:0] id; bit to;
    for (int i = 0; i < 2; i++) begin wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'hFF; end
    do_write(16'hFFF8, 8'd1, 2'b01, 3'd3, 8'h21, -1, r, id, to);
    model_write(16'hFFF8, 1, 2'b01);
    n_checks++; if (to !== 1'b0 || r !== 2'b00) begin n_fail++; $display("[TB] FAIL wrap_bresp: got to=%b resp=%b expected 0 00", to, r); end
    do_read(16'h0000, 8'd0, 2'b01, 3'd3, 8'h01, 0, to);
    n_checks++; if (to !== 1'b0 || rc_data.size() !== 1 || rc_data[0] !== wbuf_data[1]) begin n_fail++; $display("[TB] FAIL wrap_word0: got %h expected %h", (rc_data.size() > 0) ? rc_data[0] : 64'hx, wbuf_data[1]); end
    do_read(16'hFFF8, 8'd1, 2'b01, 3'd3, 8'h02, 0, to);
    n_checks++; if (to !== 1'b0 || rc_data.size() !== 2) begin n_fail++; $display("[TB] FAIL wrap_rcount: got %0d expected 2", rc_data.size()); end
    else if (rc_data[0] !== m_mem[model_idx(16'hFFF8, 0, 2'b01)] || rc_data[1] !== m_mem[model_idx(16'hFFF8, 1, 2'b01)]) begin
      n_fail++; $display("[TB] FAIL wrap_readback: got %h %h expected %h %h", rc_data[0], rc_data[1], wbuf_data[0], wbuf_data[1]);
    end
  endtask

  task automatic test_fixed_strb();
    logic [1:0] r; logic [7:0] id; bit to; logic [63:0] c_val, n_val;
    for (int i = 0; i < 3; i++) begin wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'hFF; end
    c_val = wbuf_data[2];
    do_write(16'h0080, 8'd2, 2'b00, 3'd3, 8'h33, -1, r, id, to);
    model_write(16'h0080, 2, 2'b00);
    n_checks++; if (to !== 1'b0 || r !== 2'b00 || id !== 8'h33) begin n_fail++; $display("[TB] FAIL fixed_bresp: got resp=%b id=%h expected 00 33", r, id); end
    do_read(16'h0080, 8'd0, 2'b01, 3'd3, 8'h34, 0, to);
    n_checks++; if (to !== 1'b0 || rc_data.size() !== 1 || rc_data[0] !== c_val) begin n_fail++; $display("[TB] FAIL fixed_last_wins: got %h expected %h", (rc_data.size() > 0) ? rc_data[0] : 64'hx, c_val); end
    n_val = {$urandom, $urandom};
    wbuf_data[0] = n_val; wbuf_strb[0] = 8'h0F;
    do_write(16'h0080, 8'd0, 2'b01, 3'd3, 8'h35, -1, r, id, to);
    model_write(16'h0080, 0, 2'b01);
    do_read(16'h0080, 8'd0, 2'b01, 3'd3, 8'h36, 0, to);
    n_checks++; if (to !== 1'b0 || rc_data.size() !== 1 || rc_data[0] !== {c_val[63:32], n_val[31:0]}) begin n_fail++; $display("[TB] FAIL partial_strb: got %h expected %h", (rc_data.size() > 0) ? rc_data[0] : 64'hx, {c_val[63:32], n_val[31:0]}); end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [7:0] id; bit to;
    for (int i = 0; i < 4; i++) begin wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'hFF; end
    do_write(16'h0100, 8'd3, 2'b01, 3'd3, 8'h41, 1, r, id, to);
    model_write(16'h0100, 3, 2'b01);
    n_checks++; if (to !== 1'b0 || r !== 2'b10) begin n_fail++; $display("[TB] FAIL early_wlast_bresp: got to=%b resp=%b expected 0 10", to, r); end
    do_read(16'h0100, 8'd3, 2'b01, 3'd3, 8'h42, 0, to);
    n_checks++; if (to !== 1'b0 || rc_data.size() !== 4) begin n_fail++; $display("[TB] FAIL early_wlast_count: got %0d expected 4", rc_data.size()); end
    for (int i = 0; i < rc_data.size() && i < 4; i++) begin
      n_checks++; if (rc_data[i] !== wbuf_data[i]) begin n_fail++; $display("[TB] FAIL early_wlast_beat%0d: got %h expected %h", i, rc_data[i], wbuf_data[i]); end
    end
    do_write(16'h0108, 8'd0, 2'b01, 3'd0, 8'h43, -1, r, id, to);
    model_write(16'h0108, 0, 2'b01);
    n_checks++; if (to !== 1'b0 || r !== 2'b10) begin n_fail++; $display("[TB] FAIL awsize_bresp: got resp=%b expected 10", r); end
    do_write(16'h0110, 8'd2, 2'b01, 3'd3, 8'h44, 2, r, id, to);
    model_write(16'h0110, 2, 2'b01);
    n_checks++; if (to !== 1'b0 || r !== 2'b10) begin n_fail++; $display("[TB] FAIL late_wlast_bresp: got resp=%b expected 10", r); end
    for (int i = 0; i < 2; i++) wbuf_data[i] = {$urandom, $urandom};
    do_write(16'h0140, 8'd1, 2'b11, 3'd3, 8'h45, -1, r, id, to);
    model_write(16'h0140, 1, 2'b11);
    n_checks++; if (to !== 1'b0 || r !== 2'b10) begin n_fail++; $display("[TB] FAIL reserved_burst_bresp: got resp=%b expected 10", r); end
    do_read(16'h0140, 8'd1, 2'b01, 3'd3, 8'h46, 0, to);
    n_checks++; if (to !== 1'b0 || rc_data.size() !== 2 || rc_data[1] !== wbuf_data[1] || rc_resp[1] !== 2'b00) begin n_fail++; $display("[TB] FAIL reserved_as_incr: got beats=%0d expected 2 with second %h", rc_data.size(), wbuf_data[1]); end
    do_read(16'h0100, 8'd1, 2'b01, 3'd0, 8'h47, 0, to);
    n_checks++; if (to !== 1'b0 || rc_resp.size() !== 2 || rc_resp[0] !== 2'b10 || rc_resp[1] !== 2'b10) begin n_fail++; $display("[TB] FAIL arsize_rresp: got beats=%0d expected 2 beats rresp 10", rc_resp.size()); end
    do_write(16'h0148, 8'd0, 2'b01, 3'd3, 8'h48, -1, r, id, to);
    model_write(16'h0148, 0, 2'b01);
    n_checks++; if (to !== 1'b0 || r !== 2'b00) begin n_fail++; $display("[TB] FAIL error_cleared: got resp=%b expected 00", r); end
  endtask

  task automatic test_backpressure();
    logic [1:0] r; logic [7:0] id; bit to;
    for (int i = 0; i < 8; i++) begin wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'hFF; end
    do_write(16'h0300, 8'd7, 2'b01, 3'd3, 8'h60, -1, r, id, to);
    model_write(16'h0300, 7, 2'b01);
    do_read(16'h0300, 8'd7, 2'b01, 3'd3, 8'h61, 1, to);
    n_checks++; if (to !== 1'b0 || rc_data.size() !== 8) begin n_fail++; $display("[TB] FAIL bp_count: got %0d expected 8", rc_data.size()); end
    n_checks++; if (rc_unstable !== 0) begin n_fail++; $display("[TB] FAIL bp_stable: got %0d changes while stalled expected 0", rc_unstable); end
    for (int i = 0; i < rc_data.size() && i < 8; i++) begin
      n_checks++;
      if (rc_data[i] !== wbuf_data[i] || rc_last[i] !== (i == 7)) begin
        n_fail++; $display("[TB] FAIL bp_beat%0d: got %h l=%b expected %h l=%b", i, rc_data[i], rc_last[i], wbuf_data[i], (i == 7));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] r, burst; logic [7:0] id; bit to; int addr, len, idx;
    for (int t = 0; t < 24; t++) begin
      addr  = $urandom_range(0, DEPTH - 1) * 8;
      len   = $urandom_range(0, 15);
      burst = 2'($urandom_range(0, 1));
      for (int i = 0; i <= len; i++) begin wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'($urandom); end
      do_write(16'(addr), 8'(len), burst, 3'd3, 8'(t), -1, r, id, to);
      model_write(addr, len, burst);
      n_checks++; if (to !== 1'b0 || r !== 2'b00 || id !== 8'(t)) begin n_fail++; $display("[TB] FAIL rand%0d_b: got resp=%b id=%h expected 00 %h", t, r, id, 8'(t)); end
      do_read(16'(addr), 8'(len), burst, 3'd3, 8'(t + 100), 2, to);
      n_checks++; if (to !== 1'b0 || rc_data.size() !== len + 1 || rc_unstable !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_r: got beats=%0d unstable=%0d expected %0d 0", t, rc_data.size(), rc_unstable, len + 1); end
      for (int i = 0; i < rc_data.size() && i <= len; i++) begin
        idx = model_idx(addr, i, burst);
        n_checks++;
        if ((rc_data[i] & m_known[idx]) !== (m_mem[idx] & m_known[idx]) || rc_last[i] !== (i == len) || rc_resp[i] !== 2'b00) begin
          n_fail++; $display("[TB] FAIL rand%0d_beat%0d: got %h l=%b expected %h l=%b (mask %h)", t, i, rc_data[i], rc_last[i], m_mem[idx], (i == len), m_known[idx]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int n; bit to;
    for (int i = 0; i < 2; i++) begin wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'hFF; end
    awid = 8'h70; awaddr = 16'h0200; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    n = 0; while (awready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = wbuf_data[i]; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      @(posedge clk); #1;
    end
    arid = 8'h71; araddr = 16'h0040; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
    n = 0; while (arready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; arvalid = 1'b0;
    n = 0; while (rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++; if (rvalid !== 1'b1 || wready !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_busy: got rvalid=%b wready=%b expected 1 1", rvalid, wready); end
    #1;
    rst_req_int = 1'b1;
    #1;
    n_checks++; if (rvalid !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_valids: got rvalid=%b wready=%b bvalid=%b expected 0 0 0", rvalid, wready, bvalid); end
    n_checks++; if (awready !== 1'b0 || arready !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_readies: got aw=%b ar=%b expected 0 0", awready, arready); end
    wvalid = 1'b0;
    @(negedge clk); rst_req_int = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (awready !== 1'b1 || arready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready: got aw=%b ar=%b expected 1 1", awready, arready); end
    model_write(16'h0200, 1, 2'b01);
    do_read(16'h0200, 8'd1, 2'b01, 3'd3, 8'h72, 0, to);
    n_checks++; if (to !== 1'b0 || rc_data.size() !== 2) begin n_fail++; $display("[TB] FAIL persist_count: got %0d expected 2", rc_data.size()); end
    else if (rc_data[0] !== wbuf_data[0] || rc_data[1] !== wbuf_data[1]) begin
      n_fail++; $display("[TB] FAIL persist_data: got %h %h expected %h %h", rc_data[0], rc_data[1], wbuf_data[0], wbuf_data[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = '0; end
    test_reset();
    test_incr_basic();
    test_wrap_top();
    test_fixed_strb();
    test_errors();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
